ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
AHB-Lite slave with an on-chip SRAM array. It sits directly downstream of the Master block and consumes its address and data phases. It supports byte, halfword and word reads and writes, a configurable number of wait states, and the two-cycle ERROR response for illegal transfers. It is the default memory target for Master-level and system-level simulation.

Parameters:
ADDR_WIDTH, 10, byte-address bits decoded locally; memory is 2^ADDR_WIDTH bytes, organised as 32-bit words.
WAIT_STATES, 0, number of HREADYOUT-low cycles inserted in every OKAY data phase (0..15).
MEM_BASE, 32'h0000_0000, base address of the memory window.

Ports:
HCLK  in  1  bus clock; all state changes on the rising edge.
HRESET  in  1  synchronous, active-high reset.
HSEL  in  1  slave select from the decoder.
HADDR  in  32  byte address.
HWRITE  in  1  1 = write, 0 = read.
HSIZE  in  3  0 = byte, 1 = halfword, 2 = word.
HBURST  in  3  accepted but ignored; every beat is decoded independently.
HPROT  in  4  ignored.
HTRANS  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
HMASTLOCK  in  1  ignored.
HREADY  in  1  bus-level ready; qualifies address-phase sampling.
HWDATA  in  32  write data, valid during the data phase.
HRDATA  out  32  read data.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (HRESET=1 at an edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0. Any pending data phase is discarded and nothing is written. Memory contents are not cleared.
- Address phase accepted at an edge when HSEL=1, HREADY=1 and HTRANS[1]=1. At that edge the block latches HADDR, HWRITE and HSIZE.
- IDLE/BUSY transfers, or HSEL=0, with HREADY=1 are not transfers: the next cycle is zero-wait OKAY with no memory access.
- Illegal transfer, detected at acceptance: any one of
  - (HADDR - MEM_BASE) >= 2^ADDR_WIDTH, or HADDR < MEM_BASE;
  - HSIZE > 2;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0] != 0.
- States:
  - IDLE: HREADYOUT=1, HRESP=0.
  - On an accepted legal transfer: go to DATA if WAIT_STATES=0, otherwise to WAIT with counter = WAIT_STATES.
  - On an accepted illegal transfer: go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 1, go to DATA.
  - DATA: HREADYOUT=1, HRESP=0; this is the completing cycle.
    - Write: at the closing edge, HWDATA byte lanes are written little-endian. Lanes are selected by latched HSIZE/HADDR[1:0]: byte = lane addr[1:0]; halfword = lanes {addr[1],0} and {addr[1],1}; word = all four.
    - Read: HRDATA = mem[latched word address] combinationally, full 32-bit word, all lanes driven.
    - At the same edge, a new address phase may be accepted (pipelining); the next state follows the acceptance rules, else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Next state ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new address phase may be accepted at this edge. No memory write occurs for the errored transfer.
- HRDATA is 0 in every cycle that is not a read's DATA cycle, including during WAIT.
- Read-after-write to the same word in back-to-back transfers returns the newly written data, because the write commits at the edge that starts the read's data phase.
- Address phases presented while HREADYOUT=0 are not sampled (HREADY=0).
- HRESET asserted during WAIT/ERR1/ERR2 returns to IDLE at that edge; no partial write occurs.

Test Plan:
1. Reset with HRESET=1 for 2 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0. Then drive IDLE transfers -> no state change.
2. WAIT_STATES=0: NONSEQ word write 0xAABB_CCDD to 0x4, then NONSEQ word read from 0x4 back-to-back -> read data phase HRDATA=0xAABB_CCDD, zero wait, HRESP=0 throughout.
3. Byte write 0x11 to 0x9 and halfword write 0x2233 to 0xA, over word 0x8 that previously held 0x0 -> word read from 0x8 returns 0x2233_1100.
4. WAIT_STATES=2: word read -> HREADYOUT low for exactly 2 cycles, then high with valid data. A pipelined NONSEQ held during the waits is accepted only on the completing edge.
5. Word access to 0x2 (misaligned) and to address 2^ADDR_WIDTH -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1). A subsequent read shows target memory unchanged.
6. Assert HRESET during the first WAIT cycle of a write of 0xDEAD_BEEF -> IDLE next cycle. The location retains its old value and HREADYOUT=1.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave fronting an on-chip SRAM of 2^ADDR_WIDTH bytes (32-bit words).
// Handles byte/halfword/word transfers, programmable wait states and the
// two-cycle ERROR response for out-of-window, oversized or misaligned accesses.
module ahb_lite_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned WORDS = 2 ** (ADDR_WIDTH - 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            wait_cnt;
    logic [3:0]            wait_cnt_next;

    logic [ADDR_WIDTH-1:0] offset_q;
    logic                  write_q;
    logic [1:0]            size_q;

    logic [31:0]           mem [WORDS];

    logic [31:0]           offset;
    logic                  in_range;
    logic                  size_ok;
    logic                  aligned;
    logic                  legal;
    logic                  accept;
    logic [3:0]            lane_en;

    // Burst type, protection, lock and the BUSY/SEQ distinction do not affect decoding.
    logic                  unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign offset   = HADDR - MEM_BASE;
    assign in_range = (HADDR >= MEM_BASE) && ((offset >> ADDR_WIDTH) == '0);
    assign size_ok  = (HSIZE <= 3'd2);
    assign aligned  = (HSIZE == 3'd1) ? !HADDR[0] :
                      (HSIZE == 3'd2) ? (HADDR[1:0] == 2'b00) : 1'b1;
    assign legal    = in_range && size_ok && aligned;

    // Only sample address phases while this slave is itself ready, so a bus
    // HREADY that ignores our stall cannot slip a transfer in mid-wait.
    assign accept   = HSEL && HREADY && HTRANS[1] && HREADYOUT;

    // Next-state and wait counter: a new transfer may start from IDLE, DATA or ERR2.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_next = ST_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_next = ST_DATA;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_next = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_next = ST_DATA;
                end
            end
            ST_ERR1: begin
                state_next = ST_ERR2;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bus response outputs; read data only appears in a read's completing cycle.
    always_comb begin
        HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
        HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
        HRDATA    = '0;
        if ((state == ST_DATA) && !write_q) begin
            HRDATA = mem[offset_q[ADDR_WIDTH-1:2]];
        end
    end

    // Byte-lane enables for the latched transfer, little-endian lane numbering.
    always_comb begin
        lane_en = '0;
        case (size_q)
            2'd0:    lane_en[offset_q[1:0]] = 1'b1;
            2'd1:    lane_en = offset_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Transfer state register and wait counter.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Address-phase capture on every accepted transfer, legal or not.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            offset_q <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
        end else if (accept) begin
            offset_q <= offset[ADDR_WIDTH-1:0];
            write_q  <= HWRITE;
            size_q   <= HSIZE[1:0];
        end
    end

    // Write commit at the closing edge of the data phase; memory is never cleared.
    always_ff @(posedge HCLK) begin
        if (!HRESET && (state == ST_DATA) && write_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[offset_q[ADDR_WIDTH-1:2]][i*8 +: 8] <= HWDATA[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: one instance with zero wait states and one
// with two, sharing the address/data bus and selected by tgt. Directed vectors
// come from a table; random pipelined traffic is checked cycle by cycle
// against a transfer-level reference model.
module tb_ahb_lite_sram_slave;

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        wr;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
    } beat_t;

    typedef struct {
        bit          tgt;
        bit          last;
        bit          chk;
        beat_t       b;
        logic [33:0] exp;
    } vec_t;

    localparam logic [33:0] OK_OUT  = {1'b1, 1'b0, 32'h0};
    localparam logic [33:0] ERR_OUT = {1'b1, 1'b1, 32'h0};

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        tgt;

    logic        sel0, sel2;
    logic        ready0, ready2;
    logic        resp0, resp2;
    logic [31:0] rdata0, rdata2;

    int          n_tests = 0;
    int          n_fail  = 0;

    beat_t       seq[$];
    logic [33:0] obs[$];
    vec_t        tbl[$];
    logic [31:0] mdl [2][256];

    assign sel0 = hsel && !tgt;
    assign sel2 = hsel && tgt;

    always #5 hclk = ~hclk;

    ahb_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0), .MEM_BASE(32'h0000_0000)) u_dut0 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(sel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'b001), .HPROT(4'b0011), .HTRANS(htrans), .HMASTLOCK(1'b0),
        .HREADY(ready0), .HWDATA(hwdata), .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
    );

    ahb_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2), .MEM_BASE(32'h0000_0000)) u_dut2 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(sel2), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0001), .HTRANS(htrans), .HMASTLOCK(1'b0),
        .HREADY(ready2), .HWDATA(hwdata), .HRDATA(rdata2), .HREADYOUT(ready2), .HRESP(resp2)
    );

    function automatic logic [33:0] bus_out();
        return tgt ? {ready2, resp2, rdata2} : {ready0, resp0, rdata0};
    endfunction

    function automatic logic [33:0] rd_out(input logic [31:0] d);
        return {2'b10, d};
    endfunction

    function automatic beat_t mk(input bit sel, input bit [1:0] trans, input bit wr,
                                 input bit [2:0] size, input bit [31:0] addr, input bit [31:0] wdata);
        beat_t b;
        b.sel = sel; b.trans = trans; b.wr = wr; b.size = size; b.addr = addr; b.wdata = wdata;
        return b;
    endfunction

    function automatic void tv(input bit t, input bit last, input bit chk, input beat_t b,
                               input logic [33:0] exp);
        vec_t v;
        v.tgt = t; v.last = last; v.chk = chk; v.b = b; v.exp = exp;
        tbl.push_back(v);
    endfunction

    // Legality rules: inside the 1 KiB window, size at most a word, naturally aligned.
    function automatic bit is_legal(input beat_t b);
        if (b.addr >= 32'd1024) return 1'b0;
        if (b.size > 3'd2) return 1'b0;
        if ((b.addr % (32'd1 << b.size)) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_write(input bit t, input beat_t b);
        int unsigned nbytes;
        int unsigned lane;
        nbytes = 1 << b.size;
        for (int unsigned k = 0; k < nbytes; k++) begin
            lane = (b.addr % 4) + k;
            mdl[t][b.addr / 4][lane*8 +: 8] = b.wdata[lane*8 +: 8];
        end
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int unsigned pick;
        b.sel   = ($urandom_range(0, 9) != 0);
        b.trans = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        b.wr    = 1'($urandom);
        b.size  = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        pick    = $urandom_range(0, 9);
        if (pick == 0)      b.addr = 32'd1024 + $urandom_range(0, 15);
        else if (pick == 1) b.addr = 32'h8000_0000 | $urandom;
        else                b.addr = $urandom_range(0, 63);
        b.wdata = $urandom;
        return b;
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got ready=%0b resp=%0b rdata=%08h, want ready=%0b resp=%0b rdata=%08h",
                     name, $time, act[33], act[32], act[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic drive_addr(input beat_t b);
        hsel   = b.sel;
        htrans = b.trans;
        hwrite = b.wr;
        hsize  = b.size;
        haddr  = b.addr;
    endtask

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd0;
        haddr  = 32'h0;
    endtask

    // Play seq back-to-back on the selected slave, holding each next address
    // phase through the current data phase, and check every cycle.
    task automatic run_seq();
        int unsigned ws;
        bit          acc;
        bit          ok;
        int          ncyc;
        logic [31:0] rd;
        logic [33:0] exp;
        ws = tgt ? 2 : 0;
        obs.delete();
        @(posedge hclk); #1;
        drive_addr(seq[0]);
        @(negedge hclk);
        check("addr_phase", bus_out(), OK_OUT);
        for (int i = 0; i < seq.size(); i++) begin
            acc  = seq[i].sel && seq[i].trans[1];
            ok   = is_legal(seq[i]);
            ncyc = !acc ? 1 : (!ok ? 2 : int'(ws) + 1);
            rd   = (acc && ok && !seq[i].wr) ? mdl[tgt][seq[i].addr / 4] : 32'h0;
            for (int j = 0; j < ncyc; j++) begin
                @(posedge hclk); #1;
                hwdata = seq[i].wdata;
                if (i + 1 < seq.size()) drive_addr(seq[i+1]);
                else drive_idle();
                @(negedge hclk);
                if (!acc)              exp = OK_OUT;
                else if (!ok)          exp = {(j == 1), 1'b1, 32'h0};
                else if (j < int'(ws)) exp = '0;
                else                   exp = rd_out(rd);
                check("data_phase", bus_out(), exp);
                if (j == ncyc - 1) obs.push_back(bus_out());
            end
            if (acc && ok && seq[i].wr) model_write(tgt, seq[i]);
        end
        seq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;

        hreset = 1'b1;
        hwdata = '0;
        tgt    = 1'b0;
        drive_idle();

        // Reset held for two cycles, then idle traffic on both slaves.
        repeat (2) begin
            @(posedge hclk);
            @(negedge hclk);
            check("reset_ws0", {ready0, resp0, rdata0}, OK_OUT);
            check("reset_ws2", {ready2, resp2, rdata2}, OK_OUT);
        end
        @(posedge hclk); #1;
        hreset = 1'b0;
        htrans = 2'b00;
        hsel   = 1'b1;
        repeat (3) begin
            @(negedge hclk);
            check("idle_ws0", {ready0, resp0, rdata0}, OK_OUT);
            check("idle_ws2", {ready2, resp2, rdata2}, OK_OUT);
            @(posedge hclk); #1;
        end
        drive_idle();

        // Seed the first 16 words of both memories with known contents.
        for (int t = 0; t < 2; t++) begin
            tgt = t[0];
            for (int w = 0; w < 16; w++) seq.push_back(mk(1, 2, 1, 2, 32'(w * 4), $urandom));
            run_seq();
        end

        // Zero-wait write then read back-to-back.
        tv(0, 0, 1, mk(1, 2, 1, 2, 32'h4, 32'hAABB_CCDD), OK_OUT);
        tv(0, 1, 1, mk(1, 2, 0, 2, 32'h4, 32'h0), rd_out(32'hAABB_CCDD));
        // Byte and halfword lane merging; unused lanes carry junk that must not land.
        tv(0, 0, 1, mk(1, 2, 1, 2, 32'h8, 32'h0), OK_OUT);
        tv(0, 0, 1, mk(1, 3, 1, 0, 32'h9, 32'hEEEE_11EE), OK_OUT);
        tv(0, 0, 1, mk(1, 2, 1, 1, 32'hA, 32'h2233_EEEE), OK_OUT);
        tv(0, 0, 1, mk(1, 2, 0, 2, 32'h8, 32'h0), rd_out(32'h2233_1100));
        tv(0, 0, 1, mk(1, 2, 0, 1, 32'hA, 32'h0), rd_out(32'h2233_1100));
        tv(0, 1, 1, mk(1, 2, 0, 0, 32'hB, 32'h0), rd_out(32'h2233_1100));
        // Non-transfers and illegal transfers leave word 0 untouched.
        tv(0, 0, 1, mk(1, 2, 1, 2, 32'h0, 32'h1357_9BDF), OK_OUT);
        tv(0, 0, 1, mk(1, 0, 1, 2, 32'h0, 32'hFFFF_FFFF), OK_OUT);
        tv(0, 0, 1, mk(1, 1, 1, 2, 32'h0, 32'hFFFF_FFFF), OK_OUT);
        tv(0, 0, 1, mk(0, 2, 1, 2, 32'h0, 32'hFFFF_FFFF), OK_OUT);
        tv(0, 0, 1, mk(1, 2, 1, 2, 32'h2, 32'hFFFF_FFFF), ERR_OUT);
        tv(0, 0, 1, mk(1, 2, 0, 2, 32'h400, 32'h0), ERR_OUT);
        tv(0, 0, 1, mk(1, 2, 1, 3, 32'h0, 32'hFFFF_FFFF), ERR_OUT);
        tv(0, 0, 1, mk(1, 2, 1, 1, 32'h1, 32'hFFFF_FFFF), ERR_OUT);
        tv(0, 1, 1, mk(1, 2, 0, 2, 32'h0, 32'h0), rd_out(32'h1357_9BDF));
        // Two wait states with a pipelined NONSEQ held through the stall.
        tv(1, 0, 1, mk(1, 2, 1, 2, 32'h20, 32'h0BAD_F00D), OK_OUT);
        tv(1, 0, 1, mk(1, 2, 0, 2, 32'h20, 32'h0), rd_out(32'h0BAD_F00D));
        tv(1, 0, 0, mk(1, 2, 0, 2, 32'h24, 32'h0), OK_OUT);
        tv(1, 0, 1, mk(1, 2, 0, 2, 32'h400, 32'h0), ERR_OUT);
        tv(1, 0, 1, mk(1, 2, 1, 2, 32'h21, 32'hFFFF_FFFF), ERR_OUT);
        tv(1, 1, 1, mk(1, 2, 0, 2, 32'h20, 32'h0), rd_out(32'h0BAD_F00D));

        start = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            seq.push_back(tbl[i].b);
            if (tbl[i].last) begin
                tgt = tbl[i].tgt;
                run_seq();
                for (int k = start; k <= i; k++) begin
                    if (tbl[k].chk) check("table_vec", obs[k - start], tbl[k].exp);
                end
                start = i + 1;
            end
        end

        // Reset during the first wait cycle of a write discards it.
        tgt = 1'b1;
        @(posedge hclk); #1;
        drive_addr(mk(1, 2, 1, 2, 32'h20, 32'h0));
        @(negedge hclk);
        check("rst_wait_idle", bus_out(), OK_OUT);
        @(posedge hclk); #1;
        hwdata = 32'hDEAD_BEEF;
        drive_idle();
        hreset = 1'b1;
        @(negedge hclk);
        check("rst_wait_low", bus_out(), 34'h0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        check("rst_wait_after", bus_out(), OK_OUT);
        seq.push_back(mk(1, 2, 0, 2, 32'h20, 32'h0));
        run_seq();
        check("rst_wait_keep", obs[0], rd_out(32'h0BAD_F00D));

        // Random pipelined traffic on both slaves against the model.
        for (int r = 0; r < 30; r++) begin
            tgt = r[0];
            for (int k = 0; k < 12; k++) seq.push_back(rand_beat());
            run_seq();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
